// File: rtl/visualizador_suma.sv
// visualizador_suma
//   Shows an 8-bit sum on a 4-digit multiplexed common-anode 7-segment display.
//   A load strobe captures the sum.
//   A serial shift-add-3 (double-dabble) sequence then converts it to decimal,
//   or the value is passed through as two hex digits.
//   The digits are scanned continuously, one digit every REFRESH_DIV clocks.
//
//   state  | meaning
//   REPOSO | idle, waiting for cargar; display shows stored digits
//   CONV   | 8 shift-add-3 iterations; the old display stays visible
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high reset
//   suma      in   8  unsigned value to display
//   cargar    in   1  load strobe
//   modo_hex  in   1  sampled with cargar: 1 = hex, 0 = decimal
//   ocupado   out  1  high during the 8 conversion cycles
//   segmentos out  7  bit0 = a .. bit6 = g, polarity set by SEG_ACTIVE_LOW
//   anodos    out  4  one-hot digit enable, [0] = rightmost digit, polarity set by AN_ACTIVE_LOW
module visualizador_suma #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] suma,
    input  logic       cargar,
    input  logic       modo_hex,
    output logic       ocupado,
    output logic [6:0] segmentos,
    output logic [3:0] anodos
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    typedef enum logic {REPOSO, CONV} estado_t;

    estado_t         estado;
    logic [7:0]      sr;
    logic [7:0]      valor;
    logic            modo_lat;
    logic [11:0]     bcd;
    logic [2:0]      iter;
    logic [3:0][3:0] dig_val;
    logic [3:0]      dig_on;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;

    logic [11:0]     bcd_adj;
    logic [11:0]     bcd_shift;
    logic [3:0][3:0] new_val;
    logic [3:0]      new_on;
    logic            fin;
    logic [3:0][3:0] eff_val;
    logic [3:0]      eff_on;
    logic [6:0]      seg_next;
    logic [3:0]      an_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[10:0], sr[7]};

        new_val = '0;
        new_on  = '0;
        if (modo_lat) begin
            new_val[0] = valor[3:0];
            new_val[1] = valor[7:4];
            new_on     = 4'b0011;
        end else begin
            new_val[0] = bcd_shift[3:0];
            new_val[1] = bcd_shift[7:4];
            new_val[2] = bcd_shift[11:8];
            new_on[0]  = 1'b1;
            new_on[1]  = (bcd_shift[7:4] != 4'd0) || (bcd_shift[11:8] != 4'd0);
            new_on[2]  = (bcd_shift[11:8] != 4'd0);
        end

        // The final conversion edge feeds the output registers directly, so the
        // new digits appear on the same edge on which ocupado falls.
        fin     = (estado == CONV) && (iter == 3'd7);
        eff_val = fin ? new_val : dig_val;
        eff_on  = fin ? new_on  : dig_on;

        if (eff_on[idx]) begin
            seg_next = SEG_ACTIVE_LOW ? ~seg7(eff_val[idx]) : seg7(eff_val[idx]);
            an_next  = AN_ACTIVE_LOW ? ~(4'b0001 << idx) : (4'b0001 << idx);
        end else begin
            seg_next = SEG_OFF;
            an_next  = AN_OFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado    <= REPOSO;
            ocupado   <= 1'b0;
            sr        <= '0;
            valor     <= '0;
            modo_lat  <= 1'b0;
            bcd       <= '0;
            iter      <= '0;
            dig_val   <= '0;
            dig_on    <= '0;
            cnt       <= '0;
            idx       <= '0;
            segmentos <= SEG_OFF;
            anodos    <= AN_OFF;
        end else begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            case (estado)
                REPOSO: begin
                    if (cargar) begin
                        sr       <= suma;
                        valor    <= suma;
                        modo_lat <= modo_hex;
                        bcd      <= '0;
                        iter     <= '0;
                        ocupado  <= 1'b1;
                        estado   <= CONV;
                    end
                end
                CONV: begin
                    // Hex mode runs the same iterations and ignores the BCD
                    // result, so both modes have the same latency.
                    sr   <= {sr[6:0], 1'b0};
                    bcd  <= bcd_shift;
                    iter <= iter + 3'd1;
                    if (fin) begin
                        dig_val <= new_val;
                        dig_on  <= new_on;
                        ocupado <= 1'b0;
                        estado  <= REPOSO;
                    end
                end
                default: estado <= REPOSO;
            endcase

            segmentos <= seg_next;
            anodos    <= an_next;
        end
    end

endmodule

// File: tb/tb_visualizador_suma.sv
module tb_visualizador_suma;

    localparam int RD = 4;

    logic       clk;
    logic       reset;
    logic [7:0] suma;
    logic       cargar;
    logic       modo_hex;
    logic       ocupado;
    logic [6:0] segmentos;
    logic [3:0] anodos;

    int checks = 0;
    int passes = 0;
    bit started = 0;

    visualizador_suma #(
        .REFRESH_DIV(RD),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .suma(suma),
        .cargar(cargar),
        .modo_hex(modo_hex),
        .ocupado(ocupado),
        .segmentos(segmentos),
        .anodos(anodos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] tab(input int d);
        case (d)
            0: tab = 7'h3F;  1: tab = 7'h06;  2: tab = 7'h5B;  3: tab = 7'h4F;
            4: tab = 7'h66;  5: tab = 7'h6D;  6: tab = 7'h7D;  7: tab = 7'h07;
            8: tab = 7'h7F;  9: tab = 7'h6F;  10: tab = 7'h77; 11: tab = 7'h7C;
            12: tab = 7'h39; 13: tab = 7'h5E; 14: tab = 7'h79; default: tab = 7'h71;
        endcase
    endfunction

    // Digit value for display position i, -1 means blank.
    function automatic int dig(input int v, input bit hex, input int i);
        int h, t, u;
        if (hex) begin
            if (i == 0) return v % 16;
            if (i == 1) return v / 16;
            return -1;
        end
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (i == 0) return u;
        if (i == 1) return (h != 0 || t != 0) ? t : -1;
        if (i == 2) return (h != 0) ? h : -1;
        return -1;
    endfunction

    int shown [4];
    int pend [4];
    int n_edges;
    int busy_left;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_oc;

    initial begin
        for (int i = 0; i < 4; i++) begin
            shown[i] = -1;
            pend[i] = -1;
        end
        n_edges = 0;
        busy_left = 0;
        exp_seg = 7'h7F;
        exp_an = 4'hF;
        exp_oc = 1'b0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                n_edges = 0;
                busy_left = 0;
                for (int i = 0; i < 4; i++) shown[i] = -1;
                exp_seg = 7'h7F;
                exp_an = 4'hF;
                exp_oc = 1'b0;
            end else begin
                int cur, d;
                if (busy_left > 0) begin
                    busy_left--;
                    if (busy_left == 0) shown = pend;
                end else if (cargar) begin
                    for (int i = 0; i < 4; i++) pend[i] = dig(int'(suma), modo_hex, i);
                    busy_left = 8;
                end
                exp_oc = (busy_left > 0);
                cur = (n_edges / RD) % 4;
                n_edges++;
                d = shown[cur];
                if (d < 0) begin
                    exp_seg = 7'h7F;
                    exp_an = 4'hF;
                end else begin
                    exp_seg = ~tab(d);
                    exp_an = ~(4'b0001 << cur);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("model_ocupado", 32'(ocupado), 32'(exp_oc));
                chk("model_anodos", 32'(anodos), 32'(exp_an));
                chk("model_segmentos", 32'(segmentos), 32'(exp_seg));
            end
        end
    end

    task automatic load(input logic [7:0] v, input logic hex);
        @(negedge clk);
        suma = v;
        modo_hex = hex;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (ocupado && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(ocupado), 32'd0);
    endtask

    task automatic see(input logic [3:0] an, input logic [6:0] seg, input string nm);
        int n = 0;
        while (anodos !== an && n < 8 * RD + 4) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_anode_seen"}, 32'(anodos), 32'(an));
        chk(nm, 32'(segmentos), 32'(seg));
    endtask

    task automatic never(input logic [3:0] an, input string nm);
        logic bad = 1'b0;
        for (int n = 0; n < 8 * RD; n++) begin
            @(negedge clk);
            if (anodos === an) bad = 1'b1;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        cargar = 1'b0;
        suma = '0;
        modo_hex = 1'b0;
        #1 reset = 1'b1;
        started = 1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        repeat (40) begin
            @(negedge clk);
            chk("idle_ocupado", 32'(ocupado), 32'd0);
            chk("idle_anodos", 32'(anodos), 32'hF);
            chk("idle_segmentos", 32'(segmentos), 32'h7F);
        end

        load(8'd30, 1'b0);
        n = 0;
        while (ocupado && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("busy_length", 32'(n), 32'd8);
        see(4'b1110, ~7'h3F, "d30_units");
        see(4'b1101, ~7'h4F, "d30_tens");
        never(4'b1011, "d30_hund_blank");
        never(4'b0111, "d30_d3_blank");

        load(8'd255, 1'b0);
        wait_idle("d255_idle");
        see(4'b1011, ~7'h5B, "d255_hund");
        see(4'b1101, ~7'h6D, "d255_tens");
        see(4'b1110, ~7'h6D, "d255_units");
        never(4'b0111, "d255_d3_blank");

        load(8'hAF, 1'b1);
        wait_idle("hAF_idle");
        see(4'b1110, ~7'h71, "hAF_d0");
        see(4'b1101, ~7'h77, "hAF_d1");
        never(4'b1011, "hAF_d2_blank");
        never(4'b0111, "hAF_d3_blank");

        load(8'd7, 1'b0);
        @(negedge clk);
        @(negedge clk);
        suma = 8'd99;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        wait_idle("d7_idle");
        see(4'b1110, ~7'h07, "d7_units");
        never(4'b1101, "d7_tens_blank");
        never(4'b1011, "d7_hund_blank");

        load(8'h00, 1'b1);
        wait_idle("h00_idle");
        see(4'b1110, ~7'h3F, "h00_d0");
        see(4'b1101, ~7'h3F, "h00_d1");

        load(8'd30, 1'b0);
        wait_idle("d30b_idle");
        load(8'd200, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_anodos", 32'(anodos), 32'hF);
        chk("rst_segmentos", 32'(segmentos), 32'h7F);
        @(negedge clk);
        #1 reset = 1'b0;
        never(4'b1110, "rst_no_partial");
        load(8'd5, 1'b0);
        wait_idle("d5_idle");
        see(4'b1110, ~7'h6D, "d5_units");
        never(4'b1101, "d5_tens_blank");

        started = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
